// File: rtl/punc_dmem_responder_if.sv
// Request/response bus between the PUnC core (master) and the data-memory
// responder (slave).
interface punc_dmem_responder_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_wr;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/punc_dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states,
// held response until the initiator accepts it, wrapping access counter.
module punc_dmem_responder #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  punc_dmem_responder_if.slave   bus,
  output logic [15:0]            access_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  generate
    if (WAIT_CYCLES > 15) begin : g_bad_wait
      $error("punc_dmem_responder: WAIT_CYCLES must be 0..15");
    end
    if (DEPTH_LOG2 >= ADDR_W) begin : g_bad_depth
      $error("punc_dmem_responder: DEPTH_LOG2 must be smaller than ADDR_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_wr_q, rsp_wr_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [15:0]       access_count_q, access_count_d;

  logic [DEPTH_LOG2-1:0] idx;
  logic                  oor;
  logic                  mem_we;

  // Array index and range check from the latched address.
  always_comb begin
    idx = addr_q[DEPTH_LOG2-1:0];
    oor = (addr_q[ADDR_W-1:DEPTH_LOG2] != '0);
  end

  // Next-state, access and response logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    wr_d           = wr_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_wr_d       = rsp_wr_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    access_count_d = access_count_q;
    mem_we         = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.req_wr;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_wr_d    = wr_q;
          rsp_err_d   = oor;
          rsp_rdata_d = (wr_q || oor) ? '0 : mem[idx];
          mem_we      = wr_q && !oor;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d    = 1'b0;
          rsp_wr_d       = 1'b0;
          rsp_rdata_d    = '0;
          rsp_err_d      = 1'b0;
          access_count_d = access_count_q + 16'd1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      wr_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_wr_q       <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      access_count_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wr_q           <= wr_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_wr_q       <= rsp_wr_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      access_count_q <= access_count_d;
    end
  end

  // Word array write; reset on the same edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[idx] <= wdata_q;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_wr    = rsp_wr_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign access_count  = access_count_q;

endmodule

// File: doc/punc_dmem_responder.md
Name: punc_dmem_responder

Overview:
Memory-side responder for the PUnC data-memory request interface. It accepts one read or write request at a time from the PUnC control/datapath through a valid/ready handshake. It holds each request for a programmable number of wait states, then performs the access against an internal word array. It returns a held response (read data or write acknowledge, plus an error flag) until the initiator accepts it. This lets the processor run against a memory with realistic latency instead of a zero-wait combinational array.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, request address width
DEPTH_LOG2, 8, log2 of implemented words (256); addresses >= 2^DEPTH_LOG2 are out of range
WAIT_CYCLES, 2, wait states between accept and access (0..15 legal)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  initiator presents a request
req_ready  out  1  responder can accept (high only in IDLE)
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  response held
rsp_ready  in  1  initiator accepts response
rsp_wr  out  1  echo of req_wr for this response
rsp_rdata  out  DATA_W  read data (0 for writes and errors)
rsp_err  out  1  address out of range
access_count  out  16  completed responses, wraps at 0xFFFF->0

Behaviour:
- Reset is synchronous: state=IDLE, wait counter=0, rsp_valid=0, rsp_wr=0, rsp_rdata=0, rsp_err=0, access_count=0, latched request=0. Array contents are not reset. req_ready=1 from the first cycle after the reset edge.
- req_ready = (state==IDLE); it is combinational from state only and never depends on req_valid.
- States: IDLE, BUSY, RESP.
- IDLE: if req_valid at an edge, latch req_wr/addr/wdata, load counter=WAIT_CYCLES, and go to BUSY. req_* inputs are ignored outside IDLE.
- BUSY: if counter!=0, decrement. If counter==0, perform the access on this edge and go to RESP:
  - range check uses addr[ADDR_W-1:DEPTH_LOG2]!=0 -> err.
  - write, in range: mem[addr]<=wdata; rdata<=0; err<=0.
  - write, out of range: no array change; err<=1.
  - read, in range: rdata<=mem[addr]; err<=0.
  - read, out of range: rdata<=0; err<=1.
  - rsp_wr<=latched wr; rsp_valid<=1.
- Latency: accept at edge E0; rsp_valid rises at edge E0+WAIT_CYCLES+1. With WAIT_CYCLES=0, rsp_valid rises at E0+1.
- RESP: rsp_valid, rsp_wr, rsp_rdata and rsp_err stay stable until rsp_ready is sampled high. On that edge: rsp_valid<=0, rsp_rdata<=0, rsp_err<=0, rsp_wr<=0, access_count<=access_count+1 (mod 2^16), next state IDLE.
- Throughput: at most one request per WAIT_CYCLES+3 cycles. There is no accept in the same cycle as the response handshake.
- rsp_ready while not in RESP is ignored.
- Read-after-write to the same address returns the new data, because the write commits before the read is accepted.
- Reset mid-operation:
  - reset in BUSY before the access edge abandons the request; no array write occurs.
  - reset in RESP drops the pending response without incrementing access_count.
  - reset has priority over every other event on the same edge.
- Counter width is 4 bits. WAIT_CYCLES>15 is illegal; flag it with an elaboration-time check.

Test Plan:
- After reset: req_ready=1, rsp_valid=0, access_count=0. Write 0xBEEF to addr 0x0010 with WAIT_CYCLES=2 -> rsp_valid rises exactly 3 edges after accept, rsp_wr=1, rsp_err=0, rsp_rdata=0. With rsp_ready held high, access_count=1.
- Read addr 0x0010 -> rsp_rdata=0xBEEF, rsp_err=0, rsp_wr=0. Hold rsp_ready=0 for 5 cycles -> outputs stable and req_ready=0 throughout. Release -> IDLE, access_count=2.
- Write 0x1234 to addr 0x0100 (out of range for DEPTH_LOG2=8) -> rsp_err=1. Then read 0x0000 -> array unchanged (aliasing check). Read 0x0100 -> rsp_rdata=0, rsp_err=1.
- WAIT_CYCLES=0 build: back-to-back requests with rsp_ready=1 and req_valid held high -> one accept every 3 cycles. rsp_valid rises 1 edge after each accept.
- Assert rst on the edge where BUSY has counter==1 during a write of 0xAAAA to addr 5 -> no response and mem[5] unchanged. Assert rst while in RESP -> rsp_valid=0 and access_count unchanged.
- Force access_count to 0xFFFF with 65535 requests (or a backdoor preset) -> the next completed response wraps it to 0x0000.
